registrador_entrada: RTL and testbench

Operand-entry controller for the ULA: debounces the board push-buttons and steps a 4-state entry FSM that captures operand A, operand B and the operation code from the slide switches. It is the producing side of the LED status path: its `state`, `A_registered`, `B_registered` and `OP_registered` outputs are the exact values the LED/display logic consumes. It also issues a one-cycle `op_valid` strobe to start the ULA.

---
 rtl/registrador_entrada_if.sv | 36 +++
 rtl/registrador_entrada.sv | 135 +++++++++++++
 tb/tb_registrador_entrada.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/registrador_entrada_if.sv
// Signal bundle between the operand-entry controller and the board:
// raw keys and switches in, captured operands / entry state / start strobe out.
interface registrador_entrada_if;
  logic       key_confirm_n;
  logic       key_clear_n;
  logic [9:0] sw;
  logic [1:0] state;
  logic [7:0] A_registered;
  logic [7:0] B_registered;
  logic [2:0] OP_registered;
  logic       op_valid;

  // Controller side: consumes keys and switches, produces the status values.
  modport master (
    input  key_confirm_n,
    input  key_clear_n,
    input  sw,
    output state,
    output A_registered,
    output B_registered,
    output OP_registered,
    output op_valid
  );

  // Board / LED side: drives keys and switches, observes the status values.
  modport slave (
    output key_confirm_n,
    output key_clear_n,
    output sw,
    input  state,
    input  A_registered,
    input  B_registered,
    input  OP_registered,
    input  op_valid
  );
endinterface

// File: rtl/registrador_entrada.sv
// Operand-entry controller for the ULA.
// Each push-button goes through a 2-FF synchronizer, a counting debouncer and
// a falling-edge press detector; the resulting one-cycle press pulses step a
// 4-state entry FSM that captures operand A, operand B and the operation code
// from the slide switches.
//
// Handshake: op_valid is a pure strobe with no ready/back-pressure. It is high
// for exactly one cycle, in the same cycle state first reads 11, and
// A_registered/B_registered/OP_registered are already valid and stable in that
// cycle; they stay stable until the next confirm, clear or reset.
module registrador_entrada #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  registrador_entrada_if.master bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_A    = 2'b01,
    S_B    = 2'b10,
    S_OP   = 2'b11
  } state_t;

  // Bit 0 = confirm key, bit 1 = clear key; both paths are identical.
  logic [1:0] key_raw;
  logic [1:0] press;

  assign key_raw = {bus.key_clear_n, bus.key_confirm_n};

  for (genvar g = 0; g < 2; g++) begin : g_key
    logic          sync1;
    logic          sync2;
    logic          db;
    logic          db_d;
    logic [CW-1:0] cnt;
    logic          press_q;

    // Synchronize, debounce and detect the 1->0 transition of the debounced level.
    // A sample equal to db restarts the count, so any glitch must re-earn
    // the full DEBOUNCE_CYCLES of stability.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1   <= 1'b1;
        sync2   <= 1'b1;
        db      <= 1'b1;
        db_d    <= 1'b1;
        cnt     <= '0;
        press_q <= 1'b0;
      end else begin
        sync1 <= key_raw[g];
        sync2 <= sync1;
        if (sync2 == db) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          db  <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
        db_d    <= db;
        press_q <= db_d & ~db;
      end
    end

    assign press[g] = press_q;
  end

  logic   confirm_p;
  logic   clear_p;
  state_t state_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [2:0] op_q;
  logic       op_valid_q;

  assign confirm_p = press[0];
  assign clear_p   = press[1];

  // Entry FSM: clear beats confirm; the 11->00 wrap also empties the registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      op_valid_q <= 1'b0;
    end else begin
      op_valid_q <= 1'b0;
      if (clear_p) begin
        state_q <= S_IDLE;
        a_q     <= '0;
        b_q     <= '0;
        op_q    <= '0;
      end else if (confirm_p) begin
        case (state_q)
          S_IDLE: begin
            a_q     <= bus.sw[7:0];
            state_q <= S_A;
          end
          S_A: begin
            b_q     <= bus.sw[7:0];
            state_q <= S_B;
          end
          S_B: begin
            op_q       <= bus.sw[2:0];
            op_valid_q <= 1'b1;
            state_q    <= S_OP;
          end
          default: begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  // sw[9:8] have no function in this block.
  logic unused_sw;
  assign unused_sw = ^bus.sw[9:8];

  assign bus.state         = state_q;
  assign bus.A_registered  = a_q;
  assign bus.B_registered  = b_q;
  assign bus.OP_registered = op_q;
  assign bus.op_valid      = op_valid_q;

endmodule

// File: tb/tb_registrador_entrada.sv
// Bench for registrador_entrada with a short debounce window (4 cycles).
// Driver tasks push the expected output snapshot and the edge at which it must
// appear; a monitor pops and compares whenever the outputs change.
module tb_registrador_entrada;
  localparam int DC = 4;
  localparam int LAT = DC + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  registrador_entrada_if bus ();

  registrador_entrada #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Clock / reset / edge counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: snapshot = {state, A, B, OP, op_valid}
  logic [21:0] exp_q[$];
  int          exp_cyc_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  logic [1:0] m_state;
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic [2:0] m_op;

  function automatic logic [21:0] pack(input logic ov);
    return {m_state, m_a, m_b, m_op, ov};
  endfunction

  task automatic push_exp(input logic [21:0] v, input int c);
    exp_q.push_back(v);
    exp_cyc_q.push_back(c);
  endtask

  task automatic model_reset();
    m_state = 2'b00;
    m_a = 8'h00;
    m_b = 8'h00;
    m_op = 3'b000;
  endtask

  task automatic expect_confirm(input logic [9:0] s, input int e0);
    case (m_state)
      2'b00: begin m_a = s[7:0]; m_state = 2'b01; push_exp(pack(1'b0), e0 + LAT); end
      2'b01: begin m_b = s[7:0]; m_state = 2'b10; push_exp(pack(1'b0), e0 + LAT); end
      2'b10: begin
        m_op = s[2:0];
        m_state = 2'b11;
        push_exp(pack(1'b1), e0 + LAT);
        push_exp(pack(1'b0), e0 + LAT + 1);
      end
      default: begin model_reset(); push_exp(pack(1'b0), e0 + LAT); end
    endcase
  endtask

  task automatic expect_clear(input int e0);
    logic [21:0] old;
    old = pack(1'b0);
    model_reset();
    if (pack(1'b0) != old) push_exp(pack(1'b0), e0 + LAT);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: outputs sampled 1 time unit after each edge; reset edges skipped.
  logic [21:0] prev = '0;
  logic [21:0] cur;
  logic [21:0] exp_v;
  int          exp_c;
  always @(posedge clk) begin
    #1;
    cur = {bus.state, bus.A_registered, bus.B_registered, bus.OP_registered, bus.op_valid};
    if (rst_n && cur !== prev) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: got %h at edge %0d, required no change", cur, cyc);
      end else begin
        exp_v = exp_q.pop_front();
        exp_c = exp_cyc_q.pop_front();
        if (cur !== exp_v) begin
          n_fail++;
          $display("FAIL output_value: got %h, required %h (edge %0d)", cur, exp_v, cyc);
        end
        n_checks++;
        if (cyc != exp_c) begin
          n_fail++;
          $display("FAIL output_timing: got edge %0d, required edge %0d", cyc, exp_c);
        end
      end
    end
    prev = cur;
  end

  // Driver: one full press/release of confirm and/or clear with switches s.
  task automatic press(input logic conf, input logic clr, input logic [9:0] s);
    int e0;
    @(negedge clk);
    bus.sw = s;
    e0 = cyc + 1;
    if (clr) expect_clear(e0);
    else if (conf) expect_confirm(s, e0);
    bus.key_confirm_n = ~conf;
    bus.key_clear_n = ~clr;
    repeat (10) @(negedge clk);
    bus.key_confirm_n = 1'b1;
    bus.key_clear_n = 1'b1;
    repeat (14) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  // Directed sequence
  initial begin
    int e0;
    bus.key_confirm_n = 1'b1;
    bus.key_clear_n = 1'b1;
    bus.sw = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_state", 32'(bus.state), 32'h0);
    chk("reset_a", 32'(bus.A_registered), 32'h0);
    chk("reset_b", 32'(bus.B_registered), 32'h0);
    chk("reset_op", 32'(bus.OP_registered), 32'h0);
    chk("reset_op_valid", 32'(bus.op_valid), 32'h0);

    // Full entry sequence and wrap
    press(1'b1, 1'b0, 10'h05A);
    chk("entry_state_a", 32'(bus.state), 32'h1);
    chk("entry_a", 32'(bus.A_registered), 32'h5A);
    press(1'b1, 1'b0, 10'h03C);
    chk("entry_state_b", 32'(bus.state), 32'h2);
    chk("entry_b", 32'(bus.B_registered), 32'h3C);
    press(1'b1, 1'b0, 10'h006);
    chk("entry_state_op", 32'(bus.state), 32'h3);
    chk("entry_op", 32'(bus.OP_registered), 32'h6);
    chk("entry_a_held", 32'(bus.A_registered), 32'h5A);
    press(1'b1, 1'b0, 10'h0FF);
    chk("wrap_state", 32'(bus.state), 32'h0);
    chk("wrap_a", 32'(bus.A_registered), 32'h0);
    chk("wrap_op", 32'(bus.OP_registered), 32'h0);

    // Bounce: 3 low, 1 high, 3 low -> ignored
    @(negedge clk);
    bus.sw = 10'h077;
    bus.key_confirm_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.key_confirm_n = 1'b1;
    @(negedge clk);
    bus.key_confirm_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.key_confirm_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("bounce_state", 32'(bus.state), 32'h0);
    // Then held low 20 cycles -> exactly one transition
    @(negedge clk);
    e0 = cyc + 1;
    expect_confirm(10'h077, e0);
    bus.key_confirm_n = 1'b0;
    repeat (20) @(negedge clk);
    bus.key_confirm_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("held_state", 32'(bus.state), 32'h1);
    chk("held_a", 32'(bus.A_registered), 32'h77);

    // Clear from state 10
    press(1'b0, 1'b1, 10'h000);
    press(1'b1, 1'b0, 10'h011);
    press(1'b1, 1'b0, 10'h022);
    chk("pre_clear_b", 32'(bus.B_registered), 32'h22);
    press(1'b0, 1'b1, 10'h3FF);
    chk("clear_state", 32'(bus.state), 32'h0);
    chk("clear_a", 32'(bus.A_registered), 32'h0);
    chk("clear_b", 32'(bus.B_registered), 32'h0);
    chk("clear_op_valid", 32'(bus.op_valid), 32'h0);

    // Simultaneous confirm and clear in state 10
    press(1'b1, 1'b0, 10'h033);
    press(1'b1, 1'b0, 10'h044);
    press(1'b1, 1'b1, 10'h005);
    chk("simul_state", 32'(bus.state), 32'h0);
    chk("simul_op", 32'(bus.OP_registered), 32'h0);

    // Reset in state 01 while confirm is mid-debounce (cnt = 2)
    press(1'b1, 1'b0, 10'h055);
    @(negedge clk);
    bus.sw = 10'h066;
    bus.key_confirm_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("midrst_state", 32'(bus.state), 32'h0);
    chk("midrst_a", 32'(bus.A_registered), 32'h0);
    e0 = cyc + 1;
    expect_confirm(10'h066, e0);
    repeat (10) @(negedge clk);
    bus.key_confirm_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("midrst_after_state", 32'(bus.state), 32'h1);
    chk("midrst_after_a", 32'(bus.A_registered), 32'h66);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
